// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with a one-entry skid buffer.
// Optional flush support is enabled by defining PIPE_STAGE_FLUSH_EN.
`default_nettype none

module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic push;
  logic pop;
  logic flush_act;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

`ifdef PIPE_STAGE_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // Ready comes only from registered state, so out_ready never reaches in_ready.
  assign in_ready  = !reset && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything held and any same-cycle push.
    if (flush_act) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for pipe_stage_hs with directed and random phases.
`default_nettype none

module tb_pipe_stage_hs;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [CTRL_W+DATA_W-1:0] sb_q[$];

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit flush_on();
`ifdef PIPE_STAGE_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: inputs and outputs are stable mid-cycle; handshakes seen here take effect at the next edge.
  always @(negedge clock) begin
    if (mon_en) begin
      check("sb_occupancy", 64'(occupancy), 64'(sb_q.size()));
      check("sb_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      check("sb_in_ready", 64'(in_ready), 64'(!reset && sb_q.size() < 2));
      if (!out_valid) check("sb_bubble_ctrl", 64'(out_ctrl), 64'd0);
      if (reset) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          check("sb_pop_nonempty", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            check("sb_pop_data", 64'({out_ctrl, out_data}), 64'(sb_q[0]));
            void'(sb_q.pop_front());
          end
        end
        if (flush_on()) sb_q.delete();
        else if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    // Reset held for two cycles with a pending push.
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 2'b11; out_ready = 1'b0;
    step();
    mon_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready_hi", 64'(in_ready), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Streaming.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = DATA_W'(i); in_ctrl = CTRL_W'(i);
      step();
      check("stream_data", 64'(out_data), 64'(i));
      check("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'd0);

    // Back-pressure.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 2'b01;
    step();
    in_data = 32'hB; in_ctrl = 2'b10;
    step();
    check("bp_occ_full", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_data = 32'hC; in_ctrl = 2'b11;
    step();
    check("bp_held_occ", 64'(occupancy), 64'd2);
    check("bp_held_head", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    step();
    check("bp_pop_b", 64'(out_data), 64'hB);
    step();
    check("bp_pop_c", 64'(out_data), 64'hC);
    in_valid = 1'b0;
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Bubble control zeroing.
    in_valid = 1'b1; in_data = 32'h7; in_ctrl = 2'b11;
    step();
    check("bubble_ctrl_valid", 64'(out_ctrl), 64'd3);
    in_valid = 1'b0;
    step();
    check("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);
    check("bubble_valid_zero", 64'(out_valid), 64'd0);

    // Flush while full, with a push attempt.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 2'b01;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC; flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_STAGE_FLUSH_EN
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    // Flush in BUSY discards a same-cycle push.
    in_data = 32'hD;
    step();
    in_data = 32'hE; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    step();
`else
    check("noflush_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    step();
    check("noflush_b", 64'(out_data), 64'hB);
    step();
    check("noflush_c", 64'(out_data), 64'hC);
    in_valid = 1'b0;
    step();
`endif
    check("flush_end_empty", 64'(out_valid), 64'd0);

    // Simultaneous push/pop in BUSY.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5; in_ctrl = 2'b10;
    step();
    out_ready = 1'b1; in_data = 32'h6; in_ctrl = 2'b01;
    step();
    check("pushpop_data", 64'(out_data), 64'h6);
    check("pushpop_occ", 64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      in_ctrl   = CTRL_W'($urandom);
      flush     = ($urandom_range(0, 40) == 0);
      reset     = ($urandom_range(0, 150) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (out_valid && n < 10) begin
        step();
        n++;
      end
    end
    step();
    check("drain_done", 64'(out_valid), 64'd0);
    check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake and a one-entry skid buffer, generalising the fixed-width inter-stage registers (IF/ID … MEM/WB) of the 32-bit MIPS datapath. It carries a DATA_W payload and a CTRL_W control field. It accepts stall back-pressure from downstream without a combinational ready path, and supports a pipeline flush. Control bits are forced to zero on bubbles so that downstream write-back/mem-write enables never fire on invalid slots.

## Interface
- DATA_W, 32, payload width (e.g. 96 for readData/aluResult/muxInst concatenated)
- CTRL_W, 2, control field width (e.g. WB bits); must be ≥1
- clock  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (effective only with PIPE_STAGE_FLUSH_EN)
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; = !reset && state != FULL (function of state register only)
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry payload
- out_ctrl  out  CTRL_W  main entry control; all-zero whenever out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- Storage: main register (drives outputs), skid register, state ∈ {EMPTY, BUSY, FULL}.
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- EMPTY: push → main ← in, BUSY; else stay.
- BUSY: push&pop → main ← in, stay BUSY; push only → skid ← in, FULL; pop only → EMPTY; neither → hold.
- FULL (in_ready=0): pop → main ← skid, BUSY; else hold. in_valid ignored.
- out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/BUSY/FULL.
- out_data in EMPTY: holds last value (don't-care, not checked). out_ctrl in EMPTY: zero.
- Ordering strictly FIFO; no entry is dropped or duplicated except by flush/reset.
- Flush (when enabled): highest priority after reset. State ← EMPTY; a push in the same cycle is discarded; a pop in the same cycle still counts as consumed by downstream.
- Reset: highest priority. State ← EMPTY; main, skid data and ctrl ← 0.

## Timing
- Latency: push into EMPTY stage → out_valid=1 on the next cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registered state and reset; there is no combinational path from out_ready to in_ready.
- out_ready deasserted in BUSY with push → FULL next cycle, in_ready=0 next cycle; no loss.
- Reset outputs (cycle after reset sampled high): out_valid=0, out_data=0, out_ctrl=0, occupancy=0; in_ready=0 while reset is high, and 1 on the first cycle after reset deasserts.
- Reset asserted mid-transfer: the push/pop in that cycle has no effect; the stage is empty after the edge.
- Flush: out_valid=0 and occupancy=0 on the cycle after the flush edge; in_ready=1 on that cycle.

## Configuration
- PIPE_STAGE_FLUSH_EN defined: flush behaves as above.
- Not defined: flush port remains but is ignored (no logic); state changes only by handshake/reset.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1, in_data=0xDEAD → out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=0 during reset, in_ready=1 after.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 on the following consecutive cycles, occupancy stays 1.
- Back-pressure: push 0xA then 0xB with out_ready=0 → occupancy=2, in_ready=0; third push 0xC is held off. Raise out_ready → pops 0xA, 0xB, 0xC in order.
- Bubble control: in_ctrl=2'b11 once, then in_valid=0 with out_ready=1 → out_ctrl=2'b11 for one cycle, then 2'b00 while out_valid=0.
- Flush (macro on): FULL with 0xA/0xB, flush=1 plus push of 0xC → next cycle occupancy=0, out_valid=0, and 0xC is never output. Macro off: same stimulus → 0xA, 0xB, 0xC are all delivered.
- Simultaneous push/pop in BUSY: main=0x5, push 0x6 with out_ready=1 → next cycle out_data=0x6, occupancy=1.
